// File: rtl/player_bullet_ctrl_pkg.sv
// Shared geometry, colour and state encoding for the player bullet and its neighbours.
package player_bullet_ctrl_pkg;
  localparam int HRES         = 1280;
  localparam int VRES         = 720;
  localparam int PADDLE_W     = 50;
  localparam int PADDLE_H     = 20;
  localparam int BULLET_W     = 4;
  localparam int BULLET_H     = 16;
  localparam int BULLET_SPEED = 16;
  localparam logic [23:0] BULLET_COLOR = 24'hFFFFFF;

  localparam int COOLDOWN_FRAMES = 8;
  localparam int CNT_W           = $clog2(COOLDOWN_FRAMES + 1);

  localparam logic [9:0]  BULLET_SPAWN_Y = 10'(VRES - PADDLE_H - BULLET_H);
  localparam logic [10:0] BULLET_X_OFS   = 11'((PADDLE_W - BULLET_W) / 2);

  typedef enum logic [1:0] {B_IDLE, B_FLY, B_COOLDOWN} bullet_state_t;
endpackage

// File: rtl/rise_detect.sv
// Single-cycle rising-edge pulse from a level that is already synchronous to clk.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);
  logic q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= 1'b0;
    else     q <= d;
  end

  assign rise = d & ~q;
endmodule

// File: rtl/player_bullet_ctrl.sv
// Single player bullet: fire capture, spawn above the paddle, per-frame climb, hit/cooldown, draw.
// Handshake: none; frame_tick and hit are single-cycle pulses sampled on the clock edge.
module player_bullet_ctrl
  import player_bullet_ctrl_pkg::*;
#(
  parameter logic [9:0] SPAWN_Y = BULLET_SPAWN_Y
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_tick,
  input  logic          fire,
  input  logic [10:0]   paddle_x,
  input  logic          hit,
  input  logic          game_over,
  input  logic [10:0]   hcount,
  input  logic [9:0]    vcount,
  output logic          bullet_active,
  output logic [10:0]   bullet_x,
  output logic [9:0]    bullet_y,
  output logic          pixel_on,
  output logic [23:0]   rgb,
  output logic [15:0]   shots_fired,
  output bullet_state_t state
);
  logic             fire_rise;
  logic             fire_pend;
  logic [CNT_W-1:0] cnt;

  rise_detect u_fire_rise (
    .clk  (clk),
    .rst  (rst),
    .d    (fire),
    .rise (fire_rise)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= B_IDLE;
      bullet_active <= 1'b0;
      bullet_x      <= '0;
      bullet_y      <= '0;
      shots_fired   <= '0;
      fire_pend     <= 1'b0;
      cnt           <= '0;
    end else if (game_over) begin
      state         <= B_IDLE;
      bullet_active <= 1'b0;
      fire_pend     <= 1'b0;
      cnt           <= '0;
    end else begin
      case (state)
        B_IDLE: begin
          // A press landing on the spawn tick itself is consumed by that spawn.
          if (frame_tick && fire_pend) begin
            state         <= B_FLY;
            bullet_active <= 1'b1;
            bullet_x      <= paddle_x + BULLET_X_OFS;
            bullet_y      <= SPAWN_Y;
            fire_pend     <= 1'b0;
            if (shots_fired != 16'hFFFF) shots_fired <= shots_fired + 16'd1;
          end else if (fire_rise) begin
            fire_pend <= 1'b1;
          end
        end
        B_FLY: begin
          if (hit) begin
            state         <= B_COOLDOWN;
            bullet_active <= 1'b0;
            cnt           <= CNT_W'(COOLDOWN_FRAMES - 1);
          end else if (frame_tick) begin
            if (bullet_y < 10'(BULLET_SPEED)) begin
              state         <= B_IDLE;
              bullet_active <= 1'b0;
            end else begin
              bullet_y <= bullet_y - 10'(BULLET_SPEED);
            end
          end
        end
        B_COOLDOWN: begin
          if (frame_tick) begin
            if (cnt == '0) state <= B_IDLE;
            else           cnt   <= cnt - 1'b1;
          end
        end
        default: state <= B_IDLE;
      endcase
    end
  end

  // Box edges are one bit wider so a bullet touching the right/bottom edge cannot wrap.
  logic [11:0] x_end;
  logic [10:0] y_end;
  logic        in_box;

  assign x_end  = {1'b0, bullet_x} + 12'(BULLET_W);
  assign y_end  = {1'b0, bullet_y} + 11'(BULLET_H);
  assign in_box = bullet_active
                & (hcount >= bullet_x) & ({1'b0, hcount} < x_end)
                & (vcount >= bullet_y) & ({1'b0, vcount} < y_end);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixel_on <= 1'b0;
      rgb      <= '0;
    end else begin
      pixel_on <= in_box;
      rgb      <= in_box ? BULLET_COLOR : 24'h0;
    end
  end
endmodule
